bm_if_sched: RTL and testbench

Round-robin scheduler that shares one 2-stage conditional-AND datapath (c ? a & b : 0) among NREQ requesters. It sits in front of the common if/AND micro-datapath in the regression benchmark set. It arbitrates requests, latches the winner's operands, sequences the two datapath stages through a 4-state FSM, and returns a tagged, single-cycle-valid result. One operation is in flight at a time.

---
 rtl/bm_if_pkg.sv | 14 +
 rtl/bm_if_rr_pick.sv | 33 +++
 rtl/bm_if_sched.sv | 134 +++++++++++++
 tb/tb_bm_if_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bm_if_pkg.sv
// Shared types and defaults for the bm_if micro benchmarks.
package bm_if_pkg;

  localparam int BITS_DEFAULT = 2;
  localparam int NREQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bm_if_rr_pick.sv
// Combinational round-robin picker: first set req index at or after ptr, scanning upward mod NREQ.
module bm_if_rr_pick
  import bm_if_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  winner
);

  logic [IDW-1:0] idx_s;

  // Scan from the farthest offset down so the nearest set request is the last one written.
  always_comb begin
    any    = 1'b0;
    winner = {IDW{1'b0}};
    idx_s  = {IDW{1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx_s = ptr + IDW'(i);
      if (req[idx_s]) begin
        any    = 1'b1;
        winner = idx_s;
      end else begin
        any    = any;
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/bm_if_sched.sv
// Round-robin scheduler sharing one two-stage conditional-AND datapath among NREQ requesters.
module bm_if_sched
  import bm_if_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT,
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*BITS-1:0]     a_bus,
  input  logic [NREQ*BITS-1:0]     b_bus,
  input  logic [NREQ-1:0]          c_bus,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic [BITS-1:0]          result,
  output logic [$clog2(NREQ)-1:0]  result_id,
  output logic                     result_valid
);

  localparam int IDW = $clog2(NREQ);

  state_t            state_r;
  state_t            next_s;
  logic              any_s;
  logic [IDW-1:0]    winner_s;

  logic [IDW-1:0]    ptr_r;
  logic [IDW-1:0]    w_r;
  logic [BITS-1:0]   a_l_r;
  logic [BITS-1:0]   b_l_r;
  logic              c_l_r;
  logic [BITS-1:0]   and_r;
  logic              c_r;
  logic [NREQ-1:0]   gnt_r;
  logic [BITS-1:0]   result_r;
  logic [IDW-1:0]    result_id_r;
  logic              result_valid_r;

  bm_if_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .any    (any_s),
    .winner (winner_s)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; requests are only considered while idle.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (any_s) begin
          next_s = S_GRANT;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_GRANT: next_s = S_EXEC;
      S_EXEC:  next_s = S_DONE;
      S_DONE:  next_s = S_IDLE;
      default: next_s = S_IDLE;
    endcase
  end

  // Operand capture, the two datapath stages, grant/result strobes and pointer advance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r          <= {IDW{1'b0}};
      w_r            <= {IDW{1'b0}};
      a_l_r          <= {BITS{1'b0}};
      b_l_r          <= {BITS{1'b0}};
      c_l_r          <= 1'b0;
      and_r          <= {BITS{1'b0}};
      c_r            <= 1'b0;
      gnt_r          <= {NREQ{1'b0}};
      result_r       <= {BITS{1'b0}};
      result_id_r    <= {IDW{1'b0}};
      result_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (any_s) begin
            w_r   <= winner_s;
            a_l_r <= a_bus[int'(winner_s)*BITS +: BITS];
            b_l_r <= b_bus[int'(winner_s)*BITS +: BITS];
            c_l_r <= c_bus[winner_s];
            gnt_r <= {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
          end else begin
            gnt_r <= {NREQ{1'b0}};
          end
          result_valid_r <= 1'b0;
        end
        S_GRANT: begin
          and_r <= a_l_r & b_l_r;
          c_r   <= c_l_r;
          gnt_r <= {NREQ{1'b0}};
        end
        S_EXEC: begin
          result_r       <= c_r ? and_r : {BITS{1'b0}};
          result_id_r    <= w_r;
          result_valid_r <= 1'b1;
        end
        S_DONE: begin
          // NREQ is a power of two, so the natural IDW-bit wrap gives mod NREQ.
          ptr_r          <= w_r + {{(IDW-1){1'b0}}, 1'b1};
          result_valid_r <= 1'b0;
        end
        default: begin
          gnt_r          <= {NREQ{1'b0}};
          result_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt          = gnt_r;
  assign busy         = (state_r != S_IDLE);
  assign result       = result_r;
  assign result_id    = result_id_r;
  assign result_valid = result_valid_r;

endmodule

// File: tb/tb_bm_if_sched.sv
// Self-checking bench for bm_if_sched: directed scenarios plus randomized traffic against a timeline model.
module tb_bm_if_sched;

  localparam int BITS = 2;
  localparam int NREQ = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [7:0] a_bus;
  logic [7:0] b_bus;
  logic [3:0] c_bus;
  logic [3:0] gnt;
  logic       busy;
  logic [1:0] result;
  logic [1:0] result_id;
  logic       result_valid;

  int total = 0;
  int bad   = 0;

  // Timeline model: an operation accepted at edge g grants after g, delivers after g+2,
  // and the scheduler can accept again at edge g+4.
  int         cyc = 0;
  int         m_ptr, m_free, m_gedge, m_w;
  logic [1:0] m_pend, m_res, m_id;
  logic [3:0] e_gnt;
  logic       e_busy, e_valid;
  logic [1:0] e_res, e_id;

  bm_if_sched #(.BITS(BITS), .NREQ(NREQ)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req          (req),
    .a_bus        (a_bus),
    .b_bus        (b_bus),
    .c_bus        (c_bus),
    .gnt          (gnt),
    .busy         (busy),
    .result       (result),
    .result_id    (result_id),
    .result_valid (result_valid)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_ptr = 0; m_free = 0; m_gedge = -10; m_w = 0;
    m_pend = 2'b00; m_res = 2'b00; m_id = 2'b00;
    e_gnt = 4'b0000; e_busy = 1'b0; e_valid = 1'b0; e_res = 2'b00; e_id = 2'b00;
  endtask

  task automatic tick(input logic [3:0] r, input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    int w;
    bit found;
    req = r; a_bus = a; b_bus = b; c_bus = c;
    @(posedge clock);
    cyc++;
    if (cyc >= m_free && r != 4'b0000) begin
      found = 1'b0;
      w = 0;
      for (int i = 0; i < NREQ; i++) begin
        int idx;
        idx = (m_ptr + i) % NREQ;
        if (!found && r[idx]) begin
          found = 1'b1;
          w = idx;
        end
      end
      m_gedge = cyc;
      m_w     = w;
      m_pend  = c[w] ? (a[w*BITS +: BITS] & b[w*BITS +: BITS]) : 2'b00;
      m_free  = cyc + 4;
      m_ptr   = (w + 1) % NREQ;
    end
    if (cyc == m_gedge + 2) begin
      m_res = m_pend;
      m_id  = 2'(m_w);
    end
    e_gnt   = (cyc == m_gedge) ? (4'b0001 << m_w) : 4'b0000;
    e_valid = (cyc == m_gedge + 2);
    e_busy  = (cyc >= m_gedge) && (cyc <= m_gedge + 2);
    e_res   = m_res;
    e_id    = m_id;
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req = 4'b0000;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = 4'b0000; a_bus = 8'h00; b_bus = 8'h00; c_bus = 4'b0000;
    repeat (2) @(posedge clock);
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (result !== 2'b00) begin bad++; $display("FAIL reset_result: got %b want 00", result); end
    total++; if (result_id !== 2'b00) begin bad++; $display("FAIL reset_id: got %0d want 0", result_id); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    tick(4'b0001, 8'b0000_0011, 8'b0000_0010, 4'b0001);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy1: got %b want 1", busy); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", result_valid); end
    tick(4'b0000, 8'b0000_0011, 8'b0000_0010, 4'b0001);
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_gnt_clear: got %b want 0000", gnt); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy2: got %b want 1", busy); end
    tick(4'b0000, 8'b0000_0011, 8'b0000_0010, 4'b0001);
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", result_valid); end
    total++; if (result !== 2'b10) begin bad++; $display("FAIL single_result: got %b want 10", result); end
    total++; if (result_id !== 2'd0) begin bad++; $display("FAIL single_id: got %0d want 0", result_id); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy3: got %b want 1", busy); end
    tick(4'b0000, 8'h00, 8'h00, 4'b0000);
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop: got %b want 0", result_valid); end
    total++; if (result !== 2'b10) begin bad++; $display("FAIL single_hold: got %b want 10", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", busy); end
  endtask

  task automatic test_c_gating();
    tick(4'b0100, 8'b0011_0000, 8'b0011_0000, 4'b0000);
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL cgate_gnt: got %b want 0100", gnt); end
    tick(4'b0000, 8'b0011_0000, 8'b0011_0000, 4'b0000);
    tick(4'b0000, 8'b0011_0000, 8'b0011_0000, 4'b0000);
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL cgate_valid: got %b want 1", result_valid); end
    total++; if (result !== 2'b00) begin bad++; $display("FAIL cgate_result: got %b want 00", result); end
    total++; if (result_id !== 2'd2) begin bad++; $display("FAIL cgate_id: got %0d want 2", result_id); end
    tick(4'b0000, 8'h00, 8'h00, 4'b0000);
  endtask

  task automatic test_continuous();
    int ng;
    int last;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    ng = 0;
    last = -1;
    apply_reset();
    for (int t = 0; t < 17; t++) begin
      tick(4'b1111, 8'($urandom), 8'($urandom), 4'b1111);
      total++; if (gnt !== e_gnt) begin bad++; $display("FAIL cont_gnt_model: got %b want %b", gnt, e_gnt); end
      if (gnt !== 4'b0000) begin
        if (ng < 5) begin
          total++; if (gnt !== (4'b0001 << order[ng])) begin bad++; $display("FAIL cont_order: got %b want %b", gnt, 4'b0001 << order[ng]); end
        end
        if (last >= 0) begin
          total++; if (t - last !== 4) begin bad++; $display("FAIL cont_spacing: got %0d want 4", t - last); end
        end
        last = t;
        ng++;
      end
    end
    total++; if (ng !== 5) begin bad++; $display("FAIL cont_count: got %0d want 5", ng); end
  endtask

  task automatic test_late_early();
    apply_reset();
    tick(4'b0001, 8'b0000_0001, 8'b0000_0011, 4'b0001);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL late_gnt0: got %b want 0001", gnt); end
    tick(4'b0000, 8'hFF, 8'h00, 4'b0000);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL late_busy: got %b want 1", busy); end
    tick(4'b0010, 8'b0000_1000, 8'b0000_1100, 4'b0010);
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL late_valid0: got %b want 1", result_valid); end
    total++; if (result !== 2'b01) begin bad++; $display("FAIL late_result0: got %b want 01", result); end
    total++; if (result_id !== 2'd0) begin bad++; $display("FAIL late_id0: got %0d want 0", result_id); end
    tick(4'b0010, 8'b0000_1000, 8'b0000_1100, 4'b0010);
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL late_wait: got %b want 0000", gnt); end
    tick(4'b0010, 8'b0000_1000, 8'b0000_1100, 4'b0010);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL late_gnt1: got %b want 0010", gnt); end
    tick(4'b0000, 8'h00, 8'hFF, 4'b0000);
    tick(4'b0000, 8'hFF, 8'h00, 4'b0000);
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL late_valid1: got %b want 1", result_valid); end
    total++; if (result !== 2'b10) begin bad++; $display("FAIL late_result1: got %b want 10", result); end
    total++; if (result_id !== 2'd1) begin bad++; $display("FAIL late_id1: got %0d want 1", result_id); end
    tick(4'b0000, 8'h00, 8'h00, 4'b0000);
  endtask

  task automatic test_reset_mid();
    tick(4'b0100, 8'b0011_0000, 8'b0011_0000, 4'b0100);
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rmid_gnt: got %b want 0100", gnt); end
    tick(4'b0000, 8'b0011_0000, 8'b0011_0000, 4'b0100);
    reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    total++; if (result !== 2'b00) begin bad++; $display("FAIL rmid_result: got %b want 00", result); end
    total++; if (result_id !== 2'd0) begin bad++; $display("FAIL rmid_id: got %0d want 0", result_id); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rmid_gnt_clear: got %b want 0000", gnt); end
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_valid: got %b want 0", result_valid); end
    end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    tick(4'b1000, 8'b1000_0000, 8'b1100_0000, 4'b1000);
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL rmid_gnt3: got %b want 1000", gnt); end
    tick(4'b0000, 8'h00, 8'h00, 4'b0000);
    tick(4'b0000, 8'h00, 8'h00, 4'b0000);
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL rmid_valid3: got %b want 1", result_valid); end
    total++; if (result !== 2'b10) begin bad++; $display("FAIL rmid_result3: got %b want 10", result); end
    total++; if (result_id !== 2'd3) begin bad++; $display("FAIL rmid_id3: got %0d want 3", result_id); end
    tick(4'b0000, 8'h00, 8'h00, 4'b0000);
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       prev_valid;
    apply_reset();
    prev_valid = 1'b0;
    for (int t = 0; t < 400; t++) begin
      r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      tick(r, 8'($urandom), 8'($urandom), 4'($urandom));
      total++; if (gnt !== e_gnt) begin bad++; $display("FAIL rnd_gnt t=%0d: got %b want %b", t, gnt, e_gnt); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy t=%0d: got %b want %b", t, busy, e_busy); end
      total++; if (result_valid !== e_valid) begin bad++; $display("FAIL rnd_valid t=%0d: got %b want %b", t, result_valid, e_valid); end
      total++; if (result !== e_res) begin bad++; $display("FAIL rnd_result t=%0d: got %b want %b", t, result, e_res); end
      total++; if (result_id !== e_id) begin bad++; $display("FAIL rnd_id t=%0d: got %0d want %0d", t, result_id, e_id); end
      total++; if (prev_valid && result_valid) begin bad++; $display("FAIL rnd_valid_twice t=%0d: got 1 want 0", t); end
      prev_valid = result_valid;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_c_gating();
    test_continuous();
    test_late_early();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
